// File: rtl/jk_counter_ctrl_pkg.sv
// Shared encodings for the JK counter sequencer: command opcodes and FSM states.
package jk_ctrl_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD   = 2'b00,
        OP_UP     = 2'b01,
        OP_DOWN   = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_e;

endpackage

// File: rtl/jk_counter_ctrl_if.sv
// Command handshake between the host FSM (master) and the JK sequencer (slave).
interface jk_counter_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic                        CMD_VALID;
    logic                        CMD_READY;
    logic [jk_ctrl_pkg::OP_W-1:0] CMD_OP;
    logic [WIDTH-1:0]            CMD_ARG;
    logic [CNT_W-1:0]            CMD_LEN;

    modport master (
        output CMD_VALID, CMD_OP, CMD_ARG, CMD_LEN,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_ARG, CMD_LEN,
        output CMD_READY
    );
endinterface

// File: rtl/jk_counter_ctrl_cell.sv
// Single JK flip-flop with asynchronous active-low clear.
module jk_cell (
    input  logic CP,
    input  logic CLR,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qn
);

    always_ff @(posedge CP or negedge CLR) begin
        if (!CLR) Q <= 1'b0;
        else      Q <= (J & ~Q) | (~K & Q);
    end

    assign Qn = ~Q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Command-driven sequencer stepping a bank of WIDTH JK cells (load/up/down/toggle).
// Optional macro JKC_SAT_EN: UP/DOWN saturate at the range ends and WRAP stays 0.
module jk_counter_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic               CP,
    input  logic               CLR,
    jk_counter_ctrl_if.slave   cmd,
    output logic [WIDTH-1:0]   Q,
    output logic               BUSY,
    output logic               DONE,
    output logic               WRAP
);

    state_e           state, state_nx;
    op_e              op_q;
    logic [WIDTH-1:0] arg_q;
    logic [CNT_W-1:0] rem_q, rem_nx;
    logic             wrap_q, step_wrap;
    logic             accept;
    logic [WIDTH-1:0] j, k, qn;
    logic [WIDTH-1:0] t_up, t_dn;
    logic             at_max, at_min;

    // Ripple toggle enables: a bit flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & Q[i-1];
            t_dn[i] = t_dn[i-1] & qn[i-1];
        end
    end

    assign at_max = &Q;
    assign at_min = &qn;

    always_comb begin
        j         = '0;
        k         = '0;
        step_wrap = 1'b0;
        if (state == RUN) begin
            case (op_q)
                OP_LOAD: begin
                    j = arg_q;
                    k = ~arg_q;
                end
                OP_TOGGLE: begin
                    j = arg_q;
                    k = arg_q;
                end
                OP_UP: begin
`ifdef JKC_SAT_EN
                    if (!at_max) begin
                        j = t_up;
                        k = t_up;
                    end
`else
                    j         = t_up;
                    k         = t_up;
                    step_wrap = at_max;
`endif
                end
                OP_DOWN: begin
`ifdef JKC_SAT_EN
                    if (!at_min) begin
                        j = t_dn;
                        k = t_dn;
                    end
`else
                    j         = t_dn;
                    k         = t_dn;
                    step_wrap = at_min;
`endif
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

    always_comb begin
        state_nx      = state;
        rem_nx        = rem_q;
        accept        = 1'b0;
        cmd.CMD_READY = (state == IDLE) && CLR;
        case (state)
            IDLE: begin
                if (cmd.CMD_VALID && cmd.CMD_READY) begin
                    accept = 1'b1;
                    if (cmd.CMD_OP == OP_UP || cmd.CMD_OP == OP_DOWN) rem_nx = cmd.CMD_LEN;
                    else                                              rem_nx = CNT_W'(1);
                    state_nx = (rem_nx == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                rem_nx = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CP or negedge CLR) begin
        if (!CLR) begin
            state  <= IDLE;
            rem_q  <= '0;
            op_q   <= OP_LOAD;
            arg_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_nx;
            rem_q  <= rem_nx;
            wrap_q <= step_wrap;
            if (accept) begin
                op_q  <= op_e'(cmd.CMD_OP);
                arg_q <= cmd.CMD_ARG;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_cell
            jk_cell u_cell (
                .CP (CP),
                .CLR(CLR),
                .J  (j[g]),
                .K  (k[g]),
                .Q  (Q[g]),
                .Qn (qn[g])
            );
        end
    endgenerate

    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN);
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Scoreboard bench for jk_counter_ctrl; define JKC_SAT_EN to exercise saturation.
module tb_jk_counter_ctrl;
    import jk_ctrl_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             CP = 1'b0;
    logic             CLR;
    logic [WIDTH-1:0] Q;
    logic             BUSY, DONE, WRAP;

    jk_counter_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

    jk_counter_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CP  (CP),
        .CLR (CLR),
        .cmd (cmd_if.slave),
        .Q   (Q),
        .BUSY(BUSY),
        .DONE(DONE),
        .WRAP(WRAP)
    );

    always #5 CP = ~CP;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             wrap;
        logic             done;
        logic             ready;
        logic             busy;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] model_q = '0;
    logic             mon_en  = 1'b0;
    int               vectors = 0;
    int               miscompares = 0;

    // One expectation per cycle, sampled 1ns after each rising edge.
    always @(posedge CP) begin
        #1;
        if (mon_en && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors += 5;
            if (Q !== e.q) begin
                miscompares++;
                $display("FAIL sb_q: Q=%b required %b at %0t", Q, e.q, $time);
            end
            if (WRAP !== e.wrap) begin
                miscompares++;
                $display("FAIL sb_wrap: WRAP=%b required %b at %0t", WRAP, e.wrap, $time);
            end
            if (DONE !== e.done) begin
                miscompares++;
                $display("FAIL sb_done: DONE=%b required %b at %0t", DONE, e.done, $time);
            end
            if (cmd_if.CMD_READY !== e.ready) begin
                miscompares++;
                $display("FAIL sb_ready: CMD_READY=%b required %b at %0t", cmd_if.CMD_READY, e.ready, $time);
            end
            if (BUSY !== e.busy) begin
                miscompares++;
                $display("FAIL sb_busy: BUSY=%b required %b at %0t", BUSY, e.busy, $time);
            end
        end
    end

    // Waits for READY, presents the command for one edge, and queues the expected trace.
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] arg, input logic [CNT_W-1:0] len);
        int unsigned n;
        int unsigned guard;
        logic        w;
        exp_t        e;
        guard = 0;
        while (cmd_if.CMD_READY !== 1'b1 && guard < 50) begin
            @(posedge CP);
            #1;
            guard++;
        end
        vectors++;
        if (cmd_if.CMD_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout: CMD_READY=%b required 1", cmd_if.CMD_READY);
        end
        @(negedge CP);
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_OP    = op;
        cmd_if.CMD_ARG   = arg;
        cmd_if.CMD_LEN   = len;
        n = (op == OP_UP || op == OP_DOWN) ? int'(len) : 1;
        e = '{q: model_q, wrap: 1'b0, done: (n == 0), ready: 1'b0, busy: 1'b1};
        sb.push_back(e);
        for (int unsigned s = 1; s <= n; s++) begin
            w = 1'b0;
            case (op)
                OP_LOAD:   model_q = arg;
                OP_TOGGLE: model_q = model_q ^ arg;
                OP_UP: begin
`ifdef JKC_SAT_EN
                    if (model_q != {WIDTH{1'b1}}) model_q = model_q + 1'b1;
`else
                    w       = (model_q == {WIDTH{1'b1}});
                    model_q = model_q + 1'b1;
`endif
                end
                default: begin
`ifdef JKC_SAT_EN
                    if (model_q != '0) model_q = model_q - 1'b1;
`else
                    w       = (model_q == '0);
                    model_q = model_q - 1'b1;
`endif
                end
            endcase
            e = '{q: model_q, wrap: w, done: (s == n), ready: 1'b0, busy: 1'b1};
            sb.push_back(e);
        end
        e = '{q: model_q, wrap: 1'b0, done: 1'b0, ready: 1'b1, busy: 1'b0};
        sb.push_back(e);
        @(posedge CP);
        #1;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = 2'($urandom);
        cmd_if.CMD_ARG   = WIDTH'($urandom);
        cmd_if.CMD_LEN   = CNT_W'($urandom);
    endtask

    task automatic wait_drain();
        int unsigned guard;
        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(posedge CP);
            guard++;
        end
        #2;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d entries left required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        CLR              = 1'b0;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = '0;
        cmd_if.CMD_ARG   = '0;
        cmd_if.CMD_LEN   = '0;
        repeat (2) @(posedge CP);
        #1;
        vectors += 4;
        if (Q !== 4'b0000)            begin miscompares++; $display("FAIL rst_q: Q=%b required 0000", Q); end
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin miscompares++; $display("FAIL rst_busy_done: BUSY=%b DONE=%b required 0 0", BUSY, DONE); end
        if (WRAP !== 1'b0)            begin miscompares++; $display("FAIL rst_wrap: WRAP=%b required 0", WRAP); end
        if (cmd_if.CMD_READY !== 1'b0) begin miscompares++; $display("FAIL rst_ready: CMD_READY=%b required 0", cmd_if.CMD_READY); end
        @(negedge CP);
        CLR = 1'b1;
        #1;
        vectors++;
        if (cmd_if.CMD_READY !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: CMD_READY=%b required 1", cmd_if.CMD_READY); end
        model_q = '0;
        mon_en  = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        send(OP_UP, '0, 8'd10);
        repeat (3) @(posedge CP);
        #2;
        vectors++;
        if (Q !== 4'b0011) begin miscompares++; $display("FAIL midrun_q: Q=%b required 0011", Q); end
        mon_en = 1'b0;
        sb.delete();
        CLR = 1'b0;
        #1;
        vectors += 3;
        if (Q !== 4'b0000)             begin miscompares++; $display("FAIL midrun_clr_q: Q=%b required 0000", Q); end
        if (BUSY !== 1'b0)             begin miscompares++; $display("FAIL midrun_clr_busy: BUSY=%b required 0", BUSY); end
        if (cmd_if.CMD_READY !== 1'b0) begin miscompares++; $display("FAIL midrun_clr_ready: CMD_READY=%b required 0", cmd_if.CMD_READY); end
        done_seen = 0;
        repeat (3) begin
            @(posedge CP);
            #1;
            if (DONE !== 1'b0) done_seen++;
        end
        @(negedge CP);
        CLR = 1'b1;
        repeat (3) begin
            #1;
            if (DONE !== 1'b0) done_seen++;
            @(posedge CP);
        end
        vectors++;
        if (done_seen != 0) begin miscompares++; $display("FAIL midrun_no_done: DONE high %0d samples required 0", done_seen); end
        #1;
        vectors++;
        if (cmd_if.CMD_READY !== 1'b1) begin miscompares++; $display("FAIL midrun_ready_after: CMD_READY=%b required 1", cmd_if.CMD_READY); end
        model_q = '0;
        mon_en  = 1'b1;
    endtask

    task automatic test_load();
        send(OP_LOAD, 4'b1010, 8'd0);
        wait_drain();
        vectors++;
        if (Q !== 4'b1010) begin miscompares++; $display("FAIL load_q: Q=%b required 1010", Q); end
    endtask

    task automatic test_up_wrap();
        send(OP_LOAD, 4'b1110, 8'd0);
        send(OP_UP, '0, 8'd3);
        wait_drain();
`ifndef JKC_SAT_EN
        vectors++;
        if (Q !== 4'b0001) begin miscompares++; $display("FAIL up_wrap_q: Q=%b required 0001", Q); end
`endif
    endtask

    task automatic test_down_wrap();
        send(OP_LOAD, 4'b0001, 8'd0);
        send(OP_DOWN, '0, 8'd2);
        wait_drain();
`ifndef JKC_SAT_EN
        vectors++;
        if (Q !== 4'b1111) begin miscompares++; $display("FAIL down_wrap_q: Q=%b required 1111", Q); end
`endif
    endtask

    task automatic test_toggle_len0();
        send(OP_LOAD, 4'b1010, 8'd0);
        send(OP_TOGGLE, 4'b0110, 8'd0);
        send(OP_UP, '0, 8'd0);
        wait_drain();
        vectors++;
        if (Q !== 4'b1100) begin miscompares++; $display("FAIL toggle_len0_q: Q=%b required 1100", Q); end
    endtask

`ifdef JKC_SAT_EN
    task automatic test_saturate();
        send(OP_LOAD, 4'b1101, 8'd0);
        send(OP_UP, '0, 8'd5);
        send(OP_LOAD, 4'b0010, 8'd0);
        send(OP_DOWN, '0, 8'd4);
        wait_drain();
        vectors++;
        if (Q !== 4'b0000) begin miscompares++; $display("FAIL sat_down_q: Q=%b required 0000", Q); end
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            send(2'($urandom_range(3, 0)), WIDTH'($urandom), CNT_W'($urandom_range(20, 0)));
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_load();
        test_up_wrap();
        test_down_wrap();
        test_toggle_len0();
`ifdef JKC_SAT_EN
        test_saturate();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jk_counter_ctrl.md
Name: jk_counter_ctrl

Overview:
- Sequencer that drives a bank of WIDTH JK flip-flop cells as a command-driven register/counter.
- Accepts one command at a time over a valid/ready handshake: load, count up, count down, or toggle a mask.
- Each cycle it computes the per-bit J/K inputs and steps the cells a commanded number of times.
- Reports completion with a one-cycle pulse; sits between a host FSM and the JK register bank.

Parameters:
- WIDTH, 4, number of JK cells (counter/register width).
- CNT_W, 8, width of the step-count field CMD_LEN and the internal remaining-step counter.

Ports:
- CP  in  1  clock; all state changes on rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  controller can accept a command.
- CMD_OP  in  2  00 LOAD, 01 UP, 10 DOWN, 11 TOGGLE.
- CMD_ARG  in  WIDTH  load value (LOAD) or toggle mask (TOGGLE); ignored otherwise.
- CMD_LEN  in  CNT_W  number of count steps (UP/DOWN only).
- Q  out  WIDTH  JK bank state.
- BUSY  out  1  high in RUN and DONE states.
- DONE  out  1  one-cycle completion pulse.
- WRAP  out  1  one-cycle pulse in the cycle after a step that wrapped.

Behaviour:
- CLR low, asynchronously:
  - Q=0, state IDLE, remaining=0, DONE=0, WRAP=0.
  - CMD_READY forced 0 while CLR is low.
  - Assertion in any state, including mid-RUN, aborts the command with no DONE pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - CMD_READY=1 and all J=K=0 (bank holds).
  - On an edge with CMD_VALID&CMD_READY: latch op and arg.
  - remaining = 1 for LOAD/TOGGLE, CMD_LEN for UP/DOWN.
  - Next state is RUN, or FIN if remaining==0.
- RUN: CMD_READY=0; one step is applied per edge.
  - LOAD: J[i]=arg[i], K[i]=~arg[i].
  - TOGGLE: J[i]=K[i]=arg[i].
  - UP: J[i]=K[i]=T[i], with T[0]=1 and T[i]=&Q[i-1:0].
  - DOWN: J[i]=K[i]=T[i], with T[0]=1 and T[i]=&~Q[i-1:0].
  - Each edge decrements remaining. If remaining==1 at the edge, next state is FIN.
- FIN: DONE=1 for exactly this cycle, CMD_READY=0, J=K=0. Next edge goes to IDLE.
- Latency:
  - N-step command accepted at edge t0: Q updates at t1..tN, DONE high during cycle tN→tN+1, CMD_READY=1 after tN+1.
  - LEN=0: DONE during t0→t1, Q unchanged.
- WRAP is a registered pulse. Set at the edge of an UP step from all-ones or a DOWN step from zero; cleared otherwise.
- Counting arithmetic is modulo 2^WIDTH. The cell equation is Qnext = J&~Q | ~K&Q.
- CMD_VALID or CMD_ARG changes outside IDLE are ignored, since arg and op are latched.

Optional Feature:
- Macro JKC_SAT_EN.
- Defined: UP at all-ones and DOWN at zero apply J=K=0 (hold). Remaining still decrements, so DONE timing is unchanged. WRAP is tied 0.
- Undefined: modulo wrap as above, with WRAP pulses.

Decomposition:
- Package jk_ctrl_pkg holds:
  - op encodings OP_LOAD/OP_UP/OP_DOWN/OP_TOGGLE;
  - state typedef (IDLE/RUN/FIN);
  - CMD_OP width constant.
- Sub-module jk_cell: single JK flip-flop with async active-low clear, ports CP, CLR, J, K, Q, Qn. Instantiated WIDTH times via generate.
- The controller holds only the FSM, the remaining counter, the T-chain logic and the WRAP/DONE registers.

Test Plan (WIDTH=4):
1. Reset mid-RUN: UP LEN=10 accepted, CLR pulled low after 3 steps → Q=0000, BUSY=0, DONE never pulses; CMD_READY=1 first cycle after CLR high.
2. LOAD 1010 → Q=1010 one edge after accept; DONE pulse next cycle; CMD_READY back the cycle after.
3. LOAD 1110 then UP LEN=3 → Q 1111, 0000 (WRAP pulse the following cycle), 0001; then DONE.
4. LOAD 0001 then DOWN LEN=2 → Q 0000, 1111 (WRAP pulse); DONE.
5. LOAD 1010 then TOGGLE 0110 → Q=1100; then UP LEN=0 → Q stays 1100, DONE one cycle after accept.
6. With JKC_SAT_EN defined: LOAD 1101 then UP LEN=5 → Q 1110, 1111, 1111, 1111, 1111; WRAP stays 0; DONE after the 5th edge.
